// File: rtl/mem_port_arbiter_if.sv
// Signal bundle between the fetch/load-store requesters, the arbiter and the shared memory.
// No storage; pure wiring, latency 0.
// Requesters hold req until their rvalid pulse; the memory has no backpressure.
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   localparam int BE_W = DATA_W / 8;

   // fetch port
   logic              if_req_i;
   logic [ADDR_W-1:0] if_addr_i;
   logic              if_rvalid_o;
   logic [DATA_W-1:0] if_rdata_o;
   logic              if_stall_o;

   // load/store port
   logic              dm_req_i;
   logic [ADDR_W-1:0] dm_addr_i;
   logic [BE_W-1:0]   dm_we_i;
   logic [DATA_W-1:0] dm_wdata_i;
   logic              dm_rvalid_o;
   logic [DATA_W-1:0] dm_rdata_o;
   logic              dm_stall_o;

   // control / status
   logic              halt_i;
   logic              idle_o;

   // memory side
   logic              mem_req_o;
   logic [ADDR_W-1:0] mem_addr_o;
   logic [BE_W-1:0]   mem_we_o;
   logic [DATA_W-1:0] mem_wdata_o;
   logic [DATA_W-1:0] mem_rdata_i;

   // arbiter view
   modport slave (
      input  if_req_i, if_addr_i,
      input  dm_req_i, dm_addr_i, dm_we_i, dm_wdata_i,
      input  halt_i, mem_rdata_i,
      output if_rvalid_o, if_rdata_o, if_stall_o,
      output dm_rvalid_o, dm_rdata_o, dm_stall_o,
      output idle_o,
      output mem_req_o, mem_addr_o, mem_we_o, mem_wdata_o
   );

   // pipeline + memory view
   modport master (
      output if_req_i, if_addr_i,
      output dm_req_i, dm_addr_i, dm_we_i, dm_wdata_i,
      output halt_i, mem_rdata_i,
      input  if_rvalid_o, if_rdata_o, if_stall_o,
      input  dm_rvalid_o, dm_rdata_o, dm_stall_o,
      input  idle_o,
      input  mem_req_o, mem_addr_o, mem_we_o, mem_wdata_o
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency memory between fetch and load/store; data wins unless fetch is starved.
// Latency: request seen in IDLE at N -> mem_req at N+1, rvalid at N+MEM_LATENCY+2.
// Backpressure: losers and requests arriving mid-access stall (stall_o) until a later IDLE grant.
module mem_port_arbiter #(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int MEM_LATENCY  = 1,
   parameter int STARVE_LIMIT = 4
) (
   input logic               clk,
   input logic               reset,
   mem_port_arbiter_if.slave bus
);
   localparam int BE_W = DATA_W / 8;
   localparam int SC_W = $clog2(STARVE_LIMIT + 1);
   localparam int WC_W = $clog2(MEM_LATENCY + 1);
   localparam logic [SC_W-1:0] STARVE_MAX = SC_W'(STARVE_LIMIT);
   localparam logic [WC_W-1:0] LAT        = WC_W'(MEM_LATENCY);
   localparam logic [WC_W-1:0] WC_ONE     = WC_W'(1);
   localparam logic [SC_W-1:0] SC_ONE     = SC_W'(1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t            state;
   logic              owner_dm;     // 1: load/store owns the access, 0: fetch
   logic [SC_W-1:0]   starve_cnt;
   logic [WC_W-1:0]   wait_cnt;

   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic [BE_W-1:0]   mem_we;
   logic [DATA_W-1:0] mem_wdata;
   logic              if_rvalid;
   logic              dm_rvalid;
   logic [DATA_W-1:0] if_rdata;
   logic [DATA_W-1:0] dm_rdata;
   logic              idle;

   logic              grant;
   logic              fetch_wins;

   // A grant is only possible in IDLE with halt low; fetch takes it when alone or starved.
   assign grant      = (state == IDLE) && !bus.halt_i && (bus.if_req_i || bus.dm_req_i);
   assign fetch_wins = bus.if_req_i && (!bus.dm_req_i || (starve_cnt == STARVE_MAX));

   // Access sequencer: IDLE grant -> ISSUE strobe -> WAIT for data -> RESP acknowledge.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state      <= IDLE;
         owner_dm   <= 1'b0;
         starve_cnt <= '0;
         wait_cnt   <= '0;
         mem_req    <= 1'b0;
         mem_addr   <= '0;
         mem_we     <= '0;
         mem_wdata  <= '0;
         if_rvalid  <= 1'b0;
         dm_rvalid  <= 1'b0;
         if_rdata   <= '0;
         dm_rdata   <= '0;
         idle       <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (grant) begin
                  state   <= ISSUE;
                  mem_req <= 1'b1;
                  idle    <= 1'b0;
                  if (fetch_wins) begin
                     owner_dm   <= 1'b0;
                     mem_addr   <= bus.if_addr_i;
                     mem_we     <= '0;
                     mem_wdata  <= '0;
                     starve_cnt <= '0;
                  end else begin
                     owner_dm  <= 1'b1;
                     mem_addr  <= bus.dm_addr_i;
                     mem_we    <= bus.dm_we_i;
                     mem_wdata <= bus.dm_wdata_i;
                     // Fetch lost a contested arbitration; count it, saturating.
                     if (bus.if_req_i && (starve_cnt != STARVE_MAX))
                        starve_cnt <= starve_cnt + SC_ONE;
                  end
               end
            end
            ISSUE: begin
               mem_req  <= 1'b0;
               wait_cnt <= LAT;
               state    <= WAIT;
            end
            WAIT: begin
               wait_cnt <= wait_cnt - WC_ONE;
               if (wait_cnt == WC_ONE) begin
                  state <= RESP;
                  if (owner_dm) begin
                     dm_rdata  <= bus.mem_rdata_i;
                     dm_rvalid <= 1'b1;
                  end else begin
                     if_rdata  <= bus.mem_rdata_i;
                     if_rvalid <= 1'b1;
                  end
               end
            end
            RESP: begin
               // Requests are ignored here: the acked requester drops req on this edge.
               if_rvalid <= 1'b0;
               dm_rvalid <= 1'b0;
               idle      <= 1'b1;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.mem_req_o   = mem_req;
   assign bus.mem_addr_o  = mem_addr;
   assign bus.mem_we_o    = mem_we;
   assign bus.mem_wdata_o = mem_wdata;
   assign bus.if_rvalid_o = if_rvalid;
   assign bus.dm_rvalid_o = dm_rvalid;
   assign bus.if_rdata_o  = if_rdata;
   assign bus.dm_rdata_o  = dm_rdata;
   assign bus.idle_o      = idle;
   assign bus.if_stall_o  = bus.if_req_i && !if_rvalid;
   assign bus.dm_stall_o  = bus.dm_req_i && !dm_rvalid;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: instance a (latency 1, limit 4), instance b (latency 3, limit 2).
// Inputs are driven and outputs sampled on the falling edge.
// Each memory model presents valid data only in the cycle the arbiter should capture it.
module tb_mem_port_arbiter;
   logic clk = 1'b0;
   logic reset;
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) a ();
   mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b ();

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1), .STARVE_LIMIT(4))
      u_a (.clk(clk), .reset(reset), .bus(a));
   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(3), .STARVE_LIMIT(2))
      u_b (.clk(clk), .reset(reset), .bus(b));

   function automatic logic [31:0] mem_word(input logic [31:0] ad);
      if (ad == 32'h100) return 32'h00500093;
      return ad ^ 32'h5A5A_0000;
   endfunction

   // Memory models: data valid exactly MEM_LATENCY cycles after the strobe cycle.
   int          a_cnt = 0;
   logic [31:0] a_data = '0;
   int          b_cnt = 0;
   logic [31:0] b_data = '0;
   always @(posedge clk) begin
      if (a.mem_req_o === 1'b1) begin a_cnt <= 1; a_data <= mem_word(a.mem_addr_o); end
      else if (a_cnt != 0) a_cnt <= a_cnt - 1;
      if (b.mem_req_o === 1'b1) begin b_cnt <= 3; b_data <= mem_word(b.mem_addr_o); end
      else if (b_cnt != 0) b_cnt <= b_cnt - 1;
   end
   assign a.mem_rdata_i = (a_cnt == 1) ? a_data : 32'hBAD0BAD0;
   assign b.mem_rdata_i = (b_cnt == 1) ? b_data : 32'hBAD0BAD0;

   task automatic test_reset;
      n_cmp++; if (a.mem_req_o !== 1'b0) begin n_bad++; $display("FAIL rst_a_req got=%0b exp=0", a.mem_req_o); end
      n_cmp++; if (a.mem_addr_o !== 32'h0) begin n_bad++; $display("FAIL rst_a_addr got=%h exp=0", a.mem_addr_o); end
      n_cmp++; if (a.mem_we_o !== 4'h0) begin n_bad++; $display("FAIL rst_a_we got=%h exp=0", a.mem_we_o); end
      n_cmp++; if (a.mem_wdata_o !== 32'h0) begin n_bad++; $display("FAIL rst_a_wdata got=%h exp=0", a.mem_wdata_o); end
      n_cmp++; if ({a.if_rvalid_o, a.dm_rvalid_o} !== 2'b00) begin n_bad++; $display("FAIL rst_a_rvalid got=%b exp=00", {a.if_rvalid_o, a.dm_rvalid_o}); end
      n_cmp++; if ({a.if_rdata_o, a.dm_rdata_o} !== 64'h0) begin n_bad++; $display("FAIL rst_a_rdata got=%h exp=0", {a.if_rdata_o, a.dm_rdata_o}); end
      n_cmp++; if (a.idle_o !== 1'b1) begin n_bad++; $display("FAIL rst_a_idle got=%0b exp=1", a.idle_o); end
      n_cmp++; if (b.idle_o !== 1'b1) begin n_bad++; $display("FAIL rst_b_idle got=%0b exp=1", b.idle_o); end
      n_cmp++; if (u_a.starve_cnt !== 0) begin n_bad++; $display("FAIL rst_a_starve got=%0d exp=0", u_a.starve_cnt); end
   endtask

   task automatic test_store;
      @(negedge clk); // N
      a.dm_req_i = 1'b1; a.dm_addr_i = 32'h204; a.dm_we_i = 4'b0011; a.dm_wdata_i = 32'hDEADBEEF;
      #1;
      n_cmp++; if (a.dm_stall_o !== 1'b1) begin n_bad++; $display("FAIL st_stall_n got=%0b exp=1", a.dm_stall_o); end
      @(negedge clk); // N+1
      n_cmp++; if (a.mem_req_o !== 1'b1) begin n_bad++; $display("FAIL st_req got=%0b exp=1", a.mem_req_o); end
      n_cmp++; if (a.mem_addr_o !== 32'h204) begin n_bad++; $display("FAIL st_addr got=%h exp=204", a.mem_addr_o); end
      n_cmp++; if (a.mem_we_o !== 4'b0011) begin n_bad++; $display("FAIL st_we got=%b exp=0011", a.mem_we_o); end
      n_cmp++; if (a.mem_wdata_o !== 32'hDEADBEEF) begin n_bad++; $display("FAIL st_wdata got=%h exp=deadbeef", a.mem_wdata_o); end
      for (int k = 0; k < 2; k++) begin
         n_cmp++; if ({a.if_rvalid_o, a.dm_rvalid_o} !== 2'b00) begin n_bad++; $display("FAIL st_rvalid_early got=%b exp=00", {a.if_rvalid_o, a.dm_rvalid_o}); end
         @(negedge clk); // N+2, N+3
      end
      n_cmp++; if (a.dm_rvalid_o !== 1'b1) begin n_bad++; $display("FAIL st_ack got=%0b exp=1", a.dm_rvalid_o); end
      n_cmp++; if (a.if_rvalid_o !== 1'b0) begin n_bad++; $display("FAIL st_no_fetch got=%0b exp=0", a.if_rvalid_o); end
      n_cmp++; if (a.dm_stall_o !== 1'b0) begin n_bad++; $display("FAIL st_stall_ack got=%0b exp=0", a.dm_stall_o); end
      a.dm_req_i = 1'b0; a.dm_we_i = 4'b0; a.dm_wdata_i = 32'h0;
      @(negedge clk); // N+4
      n_cmp++; if (a.dm_rvalid_o !== 1'b0) begin n_bad++; $display("FAIL st_ack_once got=%0b exp=0", a.dm_rvalid_o); end
   endtask

   task automatic test_fetch;
      @(negedge clk); // N
      a.if_req_i = 1'b1; a.if_addr_i = 32'h100;
      #1;
      n_cmp++; if (a.if_stall_o !== 1'b1) begin n_bad++; $display("FAIL f_stall_n got=%0b exp=1", a.if_stall_o); end
      @(negedge clk); // N+1
      n_cmp++; if (a.mem_req_o !== 1'b1) begin n_bad++; $display("FAIL f_req got=%0b exp=1", a.mem_req_o); end
      n_cmp++; if (a.mem_addr_o !== 32'h100) begin n_bad++; $display("FAIL f_addr got=%h exp=100", a.mem_addr_o); end
      n_cmp++; if (a.mem_we_o !== 4'h0) begin n_bad++; $display("FAIL f_we got=%b exp=0000", a.mem_we_o); end
      n_cmp++; if (a.mem_wdata_o !== 32'h0) begin n_bad++; $display("FAIL f_wdata got=%h exp=0", a.mem_wdata_o); end
      n_cmp++; if (a.idle_o !== 1'b0) begin n_bad++; $display("FAIL f_idle_busy got=%0b exp=0", a.idle_o); end
      n_cmp++; if (a.if_stall_o !== 1'b1) begin n_bad++; $display("FAIL f_stall_n1 got=%0b exp=1", a.if_stall_o); end
      @(negedge clk); // N+2
      n_cmp++; if (a.mem_req_o !== 1'b0) begin n_bad++; $display("FAIL f_req_once got=%0b exp=0", a.mem_req_o); end
      n_cmp++; if (a.if_rvalid_o !== 1'b0) begin n_bad++; $display("FAIL f_ack_early got=%0b exp=0", a.if_rvalid_o); end
      n_cmp++; if (a.if_stall_o !== 1'b1) begin n_bad++; $display("FAIL f_stall_n2 got=%0b exp=1", a.if_stall_o); end
      @(negedge clk); // N+3
      n_cmp++; if (a.if_rvalid_o !== 1'b1) begin n_bad++; $display("FAIL f_ack got=%0b exp=1", a.if_rvalid_o); end
      n_cmp++; if (a.if_rdata_o !== 32'h00500093) begin n_bad++; $display("FAIL f_rdata got=%h exp=00500093", a.if_rdata_o); end
      n_cmp++; if (a.if_stall_o !== 1'b0) begin n_bad++; $display("FAIL f_stall_ack got=%0b exp=0", a.if_stall_o); end
      n_cmp++; if (a.dm_rvalid_o !== 1'b0) begin n_bad++; $display("FAIL f_no_dm got=%0b exp=0", a.dm_rvalid_o); end
      a.if_req_i = 1'b0;
      @(negedge clk); // N+4
      n_cmp++; if (a.idle_o !== 1'b1) begin n_bad++; $display("FAIL f_idle got=%0b exp=1", a.idle_o); end
      n_cmp++; if (a.if_rdata_o !== 32'h00500093) begin n_bad++; $display("FAIL f_rdata_hold got=%h exp=00500093", a.if_rdata_o); end
   endtask

   task automatic test_both;
      @(negedge clk); // N
      a.if_req_i = 1'b1; a.if_addr_i = 32'h300;
      a.dm_req_i = 1'b1; a.dm_addr_i = 32'h400; a.dm_we_i = 4'h0;
      @(negedge clk); // N+1
      n_cmp++; if (a.mem_addr_o !== 32'h400) begin n_bad++; $display("FAIL b_addr_dm got=%h exp=400", a.mem_addr_o); end
      n_cmp++; if (u_a.starve_cnt !== 1) begin n_bad++; $display("FAIL b_starve1 got=%0d exp=1", u_a.starve_cnt); end
      @(negedge clk); // N+2
      @(negedge clk); // N+3
      n_cmp++; if (a.dm_rvalid_o !== 1'b1) begin n_bad++; $display("FAIL b_dm_ack got=%0b exp=1", a.dm_rvalid_o); end
      n_cmp++; if (a.dm_rdata_o !== mem_word(32'h400)) begin n_bad++; $display("FAIL b_dm_rdata got=%h exp=%h", a.dm_rdata_o, mem_word(32'h400)); end
      n_cmp++; if (a.if_stall_o !== 1'b1) begin n_bad++; $display("FAIL b_if_stalled got=%0b exp=1", a.if_stall_o); end
      a.dm_req_i = 1'b0;
      @(negedge clk); // N+4
      n_cmp++; if (a.idle_o !== 1'b1) begin n_bad++; $display("FAIL b_idle_n4 got=%0b exp=1", a.idle_o); end
      @(negedge clk); // N+5
      n_cmp++; if (a.mem_addr_o !== 32'h300) begin n_bad++; $display("FAIL b_addr_if got=%h exp=300", a.mem_addr_o); end
      n_cmp++; if (u_a.starve_cnt !== 0) begin n_bad++; $display("FAIL b_starve0 got=%0d exp=0", u_a.starve_cnt); end
      @(negedge clk); // N+6
      n_cmp++; if (a.if_rvalid_o !== 1'b0) begin n_bad++; $display("FAIL b_if_early got=%0b exp=0", a.if_rvalid_o); end
      @(negedge clk); // N+7
      n_cmp++; if (a.if_rvalid_o !== 1'b1) begin n_bad++; $display("FAIL b_if_ack got=%0b exp=1", a.if_rvalid_o); end
      n_cmp++; if (a.if_rdata_o !== mem_word(32'h300)) begin n_bad++; $display("FAIL b_if_rdata got=%h exp=%h", a.if_rdata_o, mem_word(32'h300)); end
      a.if_req_i = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_halt;
      @(negedge clk); // N
      a.dm_req_i = 1'b1; a.dm_addr_i = 32'h480; a.dm_we_i = 4'h0;
      @(negedge clk); // N+1
      @(negedge clk); // N+2 (WAIT)
      a.halt_i = 1'b1; a.if_req_i = 1'b1; a.if_addr_i = 32'h500;
      @(negedge clk); // N+3
      n_cmp++; if (a.dm_rvalid_o !== 1'b1) begin n_bad++; $display("FAIL h_ack got=%0b exp=1", a.dm_rvalid_o); end
      n_cmp++; if (a.dm_rdata_o !== mem_word(32'h480)) begin n_bad++; $display("FAIL h_rdata got=%h exp=%h", a.dm_rdata_o, mem_word(32'h480)); end
      a.dm_req_i = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk); // N+4 .. N+8
         n_cmp++; if (a.mem_req_o !== 1'b0) begin n_bad++; $display("FAIL h_blocked c%0d got=%0b exp=0", k, a.mem_req_o); end
         n_cmp++; if (a.idle_o !== 1'b1) begin n_bad++; $display("FAIL h_idle c%0d got=%0b exp=1", k, a.idle_o); end
         n_cmp++; if (a.if_stall_o !== 1'b1) begin n_bad++; $display("FAIL h_stall c%0d got=%0b exp=1", k, a.if_stall_o); end
      end
      a.halt_i = 1'b0;
      @(negedge clk); // N+9
      n_cmp++; if (a.mem_req_o !== 1'b1 || a.mem_addr_o !== 32'h500) begin n_bad++; $display("FAIL h_resume got=%0b/%h exp=1/500", a.mem_req_o, a.mem_addr_o); end
      @(negedge clk);
      @(negedge clk); // N+11
      n_cmp++; if (a.if_rvalid_o !== 1'b1) begin n_bad++; $display("FAIL h_if_ack got=%0b exp=1", a.if_rvalid_o); end
      a.if_req_i = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_starve;
      logic exp_dm [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      logic got_dm [6];
      int   when   [6];
      int   n_ack = 0;
      @(negedge clk); // cycle 0
      b.if_req_i = 1'b1; b.if_addr_i = 32'h700;
      b.dm_req_i = 1'b1; b.dm_addr_i = 32'h600; b.dm_we_i = 4'h0;
      for (int c = 1; c <= 80 && n_ack < 6; c++) begin
         @(negedge clk);
         n_cmp++; if (b.if_rvalid_o === 1'b1 && b.dm_rvalid_o === 1'b1) begin n_bad++; $display("FAIL sv_excl cyc%0d got=11 exp=not both", c); end
         if (b.dm_rvalid_o === 1'b1 || b.if_rvalid_o === 1'b1) begin
            got_dm[n_ack] = b.dm_rvalid_o;
            when[n_ack]   = c;
            n_cmp++;
            if (b.dm_rvalid_o === 1'b1 ? (b.dm_rdata_o !== mem_word(32'h600)) : (b.if_rdata_o !== mem_word(32'h700))) begin
               n_bad++; $display("FAIL sv_rdata ack%0d got=%h/%h", n_ack, b.dm_rdata_o, b.if_rdata_o);
            end
            n_ack++;
         end
      end
      b.if_req_i = 1'b0; b.dm_req_i = 1'b0;
      n_cmp++; if (n_ack !== 6) begin n_bad++; $display("FAIL sv_count got=%0d exp=6", n_ack); end
      for (int i = 0; i < n_ack; i++) begin
         n_cmp++; if (got_dm[i] !== exp_dm[i]) begin n_bad++; $display("FAIL sv_order ack%0d got_dm=%0b exp_dm=%0b", i, got_dm[i], exp_dm[i]); end
         n_cmp++; if (when[i] !== 5 + 6 * i) begin n_bad++; $display("FAIL sv_time ack%0d got=%0d exp=%0d", i, when[i], 5 + 6 * i); end
      end
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset_wait;
      @(negedge clk); // N
      b.dm_req_i = 1'b1; b.dm_addr_i = 32'h800; b.dm_we_i = 4'h0;
      @(negedge clk); // N+1
      @(negedge clk); // N+2
      @(negedge clk); // N+3 (WAIT, two cycles left)
      n_cmp++; if (b.dm_rvalid_o !== 1'b0) begin n_bad++; $display("FAIL rw_pre got=%0b exp=0", b.dm_rvalid_o); end
      reset = 1'b0;
      @(negedge clk); // N+4
      n_cmp++; if (b.mem_req_o !== 1'b0 || b.mem_addr_o !== 32'h0 || b.mem_we_o !== 4'h0 || b.mem_wdata_o !== 32'h0) begin
         n_bad++; $display("FAIL rw_mem got=%0b/%h/%h/%h exp=0/0/0/0", b.mem_req_o, b.mem_addr_o, b.mem_we_o, b.mem_wdata_o);
      end
      n_cmp++; if ({b.if_rvalid_o, b.dm_rvalid_o} !== 2'b00) begin n_bad++; $display("FAIL rw_rvalid got=%b exp=00", {b.if_rvalid_o, b.dm_rvalid_o}); end
      n_cmp++; if ({b.if_rdata_o, b.dm_rdata_o} !== 64'h0) begin n_bad++; $display("FAIL rw_rdata got=%h exp=0", {b.if_rdata_o, b.dm_rdata_o}); end
      n_cmp++; if (b.idle_o !== 1'b1) begin n_bad++; $display("FAIL rw_idle got=%0b exp=1", b.idle_o); end
      n_cmp++; if (u_b.wait_cnt !== 0) begin n_bad++; $display("FAIL rw_wait_cnt got=%0d exp=0", u_b.wait_cnt); end
      reset = 1'b1;
      @(negedge clk); // N+5
      n_cmp++; if (b.mem_req_o !== 1'b1 || b.mem_addr_o !== 32'h800) begin n_bad++; $display("FAIL rw_regrant got=%0b/%h exp=1/800", b.mem_req_o, b.mem_addr_o); end
      for (int k = 6; k <= 8; k++) begin
         @(negedge clk);
         n_cmp++; if (b.dm_rvalid_o !== 1'b0) begin n_bad++; $display("FAIL rw_early N+%0d got=%0b exp=0", k, b.dm_rvalid_o); end
      end
      @(negedge clk); // N+9
      n_cmp++; if (b.dm_rvalid_o !== 1'b1) begin n_bad++; $display("FAIL rw_ack got=%0b exp=1", b.dm_rvalid_o); end
      n_cmp++; if (b.dm_rdata_o !== mem_word(32'h800)) begin n_bad++; $display("FAIL rw_data got=%h exp=%h", b.dm_rdata_o, mem_word(32'h800)); end
      b.dm_req_i = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      reset = 1'b0;
      a.if_req_i = 1'b0; a.if_addr_i = '0; a.dm_req_i = 1'b0; a.dm_addr_i = '0;
      a.dm_we_i = '0; a.dm_wdata_i = '0; a.halt_i = 1'b0;
      b.if_req_i = 1'b0; b.if_addr_i = '0; b.dm_req_i = 1'b0; b.dm_addr_i = '0;
      b.dm_we_i = '0; b.dm_wdata_i = '0; b.halt_i = 1'b0;
      repeat (3) @(negedge clk);
      test_reset;
      reset = 1'b1;
      @(negedge clk);
      test_store;
      test_fetch;
      test_both;
      test_halt;
      test_starve;
      test_reset_wait;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-ported, fixed-latency memory between the instruction-fetch port and the load/store port of the RV32IM_Zbb core. It arbitrates with data-port priority and an instruction-fetch anti-starvation limit. It sequences each access through issue, wait and response phases, and returns one acknowledge per access. It sits between the pipeline's IF/MEM stages and the unified memory model, and replaces direct instruction-memory and data-memory hookups.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width; byte-enable width is DATA_W/8
- MEM_LATENCY, 1, cycles from the mem_req_o cycle to valid mem_rdata_i; must be ≥1
- STARVE_LIMIT, 4, consecutive lost arbitrations after which fetch wins; must be ≥1
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-low reset
- if_req_i  in  1  fetch request, held until if_rvalid_o
- if_addr_i  in  ADDR_W  fetch address, stable while if_req_i is high
- dm_req_i  in  1  load/store request, held until dm_rvalid_o
- dm_addr_i  in  ADDR_W  data address
- dm_we_i  in  DATA_W/8  byte enables; 0 means load
- dm_wdata_i  in  DATA_W  store data
- halt_i  in  1  stop flag; blocks new grants
- if_rvalid_o  out  1  one-cycle fetch acknowledge
- if_rdata_o  out  DATA_W  fetched word
- dm_rvalid_o  out  1  one-cycle data acknowledge (loads and stores)
- dm_rdata_o  out  DATA_W  load data; don't-care for stores
- if_stall_o, dm_stall_o  out  1 each  high when req_i is high and rvalid_o is low (combinational)
- mem_req_o  out  1  one-cycle access strobe
- mem_addr_o  out  ADDR_W  registered address
- mem_we_o  out  DATA_W/8  registered byte enables
- mem_wdata_o  out  DATA_W  registered store data
- mem_rdata_i  in  DATA_W  memory read data
- idle_o  out  1  high in IDLE with no access in flight

## Operation
- States are IDLE, ISSUE, WAIT and RESP; one access is in flight at most.
- IDLE: if halt_i is low and any request is present, pick a winner, latch its addr/we/wdata into the mem_*_o registers, record the owner, and go to ISSUE. Otherwise stay in IDLE.
- Arbitration:
  - The data port wins by default.
  - The fetch port wins if it is the only requester, or if starve_cnt == STARVE_LIMIT.
- starve_cnt:
  - Increments when both ports request and data wins.
  - Clears when fetch is granted.
  - Saturates at STARVE_LIMIT.
- ISSUE: mem_req_o is high for exactly this cycle. Load wait_cnt with MEM_LATENCY and go to WAIT.
- WAIT:
  - Decrement wait_cnt each cycle.
  - In the cycle where wait_cnt == 1, capture mem_rdata_i into the owner's rdata register and go to RESP.
  - MEM_LATENCY=1 means a single WAIT cycle.
- RESP: the owner's rvalid_o is high for exactly one cycle, then go to IDLE. Requests are not sampled in RESP, because the acked requester drops req on the next edge.
- rdata_o holds its last captured value until the next capture for that port.
- halt_i only gates the IDLE grant. An access already in flight completes normally, and idle_o rises after RESP.
- mem_we_o/mem_wdata_o are zero for fetches. The arbiter passes dm_we_i through unmodified.

## Timing
- Reset values (reset low at a rising edge):
  - State IDLE; starve_cnt 0; wait_cnt 0.
  - All mem_*_o are 0; both rvalid_o are 0; both rdata_o are 0.
  - idle_o is 1.
- Reset has priority over every state. Asserting it in ISSUE, WAIT or RESP aborts the access and suppresses its rvalid.
- Latency: a request first seen in IDLE at cycle N gives mem_req_o at N+1, capture at N+MEM_LATENCY+1, and rvalid_o at N+MEM_LATENCY+2.
- Back-to-back throughput is one access every MEM_LATENCY+3 cycles.
- Simultaneous requests in IDLE are resolved in that same cycle. The loser stays stalled and is arbitrated again at the next IDLE cycle.
- A request that rises during ISSUE, WAIT or RESP waits for IDLE.
- At most one of if_rvalid_o and dm_rvalid_o is ever high.

## Test plan
- Single fetch with MEM_LATENCY=1 and if_addr_i=0x100: mem_req_o high at N+1 with addr 0x100 and we 0; memory returns 0x00500093; if_rvalid_o pulses at N+3 with if_rdata_o=0x00500093; if_stall_o is high for N..N+2.
- Store halfword (dm_we_i=4'b0011, addr 0x204, wdata 0xDEADBEEF): mem_we_o=0011 and mem_wdata_o=0xDEADBEEF during ISSUE; dm_rvalid_o pulses at N+3; no fetch activity.
- Both ports request at cycle N: data is served first (dm_rvalid_o at N+3), then fetch (IDLE at N+4, if_rvalid_o at N+7); starve_cnt reads 1 and then 0.
- STARVE_LIMIT=2, both ports requesting continuously: the grant order is D, D, I, D, D, I; no port waits more than 3 accesses.
- halt_i asserted during WAIT of a load: the load still acks; no further mem_req_o while halt_i is high, although if_req_i is high; idle_o is 1 from the cycle after RESP.
- Reset driven low during WAIT (MEM_LATENCY=3): no rvalid pulse; all outputs return to their reset values at the next edge; the first request after reset release is granted normally.
